// File: rtl/usb_buffer_arbiter.sv
// Endpoint data buffer with ownership FSM: one writer side, one reader side
// per phase. Dropped accesses pulse access_err for one cycle.
// Ports: clk, n_rst; RX store/flush/done; TX get/start; AHB store/get/clear;
//        rd_data, buffer_occupancy, buf_state, access_err.
module usb_buffer_arbiter #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int OCC_W  = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             flush,
    input  logic             rx_packet_done,
    input  logic             get_tx_packet_data,
    input  logic             tx_packet_start,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    input  logic             clear,
    output logic [7:0]       rd_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic [2:0]       buf_state,
    output logic             access_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_FILL   = 3'd1,
        HOST_READ = 3'd2,
        HOST_FILL = 3'd3,
        TX_READ   = 3'd4
    } state_t;

    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [7:0]        rd_data_q;
    logic              err_q, err_d;
    logic [7:0]        mem [DEPTH];

    logic       kill;
    logic       wr_req, rd_req, bad_req;
    logic       wr_en, rd_en;
    logic [7:0] wr_byte;

    assign kill = flush | clear;

    // Decode which strobe is legal for the current owner; anything else is bad.
    always_comb begin
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        bad_req = 1'b0;
        wr_byte = rx_packet_data;
        unique case (state_q)
            IDLE: begin
                if (store_rx_packet_data) begin
                    wr_req  = 1'b1;
                    bad_req = store_tx_data | get_rx_data | get_tx_packet_data;
                end else if (store_tx_data) begin
                    wr_req  = 1'b1;
                    wr_byte = tx_data;
                    bad_req = get_rx_data | get_tx_packet_data;
                end else begin
                    bad_req = get_rx_data | get_tx_packet_data;
                end
            end
            RX_FILL: begin
                wr_req  = store_rx_packet_data;
                bad_req = store_tx_data | get_rx_data | get_tx_packet_data;
            end
            HOST_FILL: begin
                wr_req  = store_tx_data;
                wr_byte = tx_data;
                bad_req = store_rx_packet_data | get_rx_data | get_tx_packet_data;
            end
            HOST_READ: begin
                rd_req  = get_rx_data;
                bad_req = store_rx_packet_data | store_tx_data | get_tx_packet_data;
            end
            TX_READ: begin
                rd_req  = get_tx_packet_data;
                bad_req = store_rx_packet_data | store_tx_data | get_rx_data;
            end
            default: ;
        endcase
    end

    assign wr_en = wr_req & (occ_q != FULL) & ~kill;
    assign rd_en = rd_req & (occ_q != '0) & ~kill;

    always_comb begin
        occ_d   = occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
        err_d   = ~kill & (bad_req | (wr_req & ~wr_en) | (rd_req & ~rd_en));
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (store_rx_packet_data)
                    state_d = RX_FILL;
                else if (store_tx_data)
                    state_d = HOST_FILL;
            end
            RX_FILL: begin
                if (rx_packet_done)
                    state_d = (occ_d != '0) ? HOST_READ : IDLE;
            end
            HOST_FILL: begin
                if (tx_packet_start)
                    state_d = TX_READ;
            end
            HOST_READ, TX_READ: begin
                // Last byte popped: release ownership.
                if (rd_en && occ_q == OCC_W'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            rd_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else if (kill) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
            if (wr_en)
                wptr_q <= wptr_q + ADDR_W'(1);
            if (rd_en) begin
                rptr_q    <= rptr_q + ADDR_W'(1);
                rd_data_q <= mem[rptr_q];
            end
        end
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr_q] <= wr_byte;
    end

    assign rd_data          = rd_data_q;
    assign buffer_occupancy = occ_q;
    assign buf_state        = state_q;
    assign access_err       = err_q;

endmodule
